rename_regfile: RTL and testbench

RENAME_REGFILE -- requirements
Module: rename_regfile

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_read_port.sv | 65 ++++++
 rtl/rename_regfile.sv | 137 +++++++++++++
 tb/tb_rename_regfile.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults and constants for the rename register file.
// Build option RENAME_REGFILE_BYPASS_EN forwards same-cycle commit data to reads.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int TAG_W_DEF = 4;

    // Tag value meaning "no producer in flight"; register 0 is hardwired empty.
    localparam int EMPTY_TAG = 0;
    localparam int EMPTY_REG = 0;

`ifdef RENAME_REGFILE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/rf_read_port.sv
// Single combinational read lookup of the rename register file.
// With RENAME_REGFILE_BYPASS_EN, a same-cycle commit that would retire the entry is forwarded.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int NCM   = 2,
    parameter int RW    = $clog2(NREG)
) (
    input  logic [RW-1:0]         rd_idx,
    input  logic [NREG*XLEN-1:0]  data_flat,
    input  logic [NREG*TAG_W-1:0] tag_flat,
    input  logic [NCM-1:0]        cm_valid,
    input  logic [NCM*RW-1:0]     cm_idx,
    input  logic [NCM*XLEN-1:0]   cm_data,
    input  logic [NCM*TAG_W-1:0]  cm_tag,
    output logic [XLEN-1:0]       rd_data,
    output logic [TAG_W-1:0]      rd_tag
);

    logic             in_range_s;
    logic [XLEN-1:0]  stored_data_s;
    logic [TAG_W-1:0] stored_tag_s;
    logic             byp_hit_s;
    logic [XLEN-1:0]  byp_data_s;

    // Fetch the addressed entry from the flattened state.
    always_comb begin
        in_range_s    = (int'(rd_idx) < NREG);
        stored_data_s = data_flat[int'(rd_idx)*XLEN +: XLEN];
        stored_tag_s  = tag_flat[int'(rd_idx)*TAG_W +: TAG_W];
    end

    // Highest-numbered commit port addressing this register decides the forward.
    always_comb begin
        byp_hit_s  = 1'b0;
        byp_data_s = '0;
        for (int p = 0; p < NCM; p++) begin
            byp_hit_s  = (cm_valid[p] && (cm_idx[p*RW +: RW] == rd_idx))
                         ? (cm_tag[p*TAG_W +: TAG_W] == stored_tag_s) : byp_hit_s;
            byp_data_s = (cm_valid[p] && (cm_idx[p*RW +: RW] == rd_idx))
                         ? cm_data[p*XLEN +: XLEN] : byp_data_s;
        end
    end

    // Pending entries hide their stale data behind the tag.
    always_comb begin
        if ((rd_idx == RW'(EMPTY_REG)) || !in_range_s) begin
            rd_data = '0;
            rd_tag  = '0;
        end else if (BYPASS_EN && byp_hit_s) begin
            rd_data = byp_data_s;
            rd_tag  = TAG_W'(EMPTY_TAG);
        end else if (stored_tag_s == TAG_W'(EMPTY_TAG)) begin
            rd_data = stored_data_s;
            rd_tag  = stored_tag_s;
        end else begin
            rd_data = '0;
            rd_tag  = stored_tag_s;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename tags, multi-port commit and busy counter.
// Build option RENAME_REGFILE_BYPASS_EN (see rf_read_port) enables commit-to-read forwarding.
module rename_regfile
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int NRD   = 2,
    parameter int NCM   = 2,
    localparam int RW   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  clear,
    input  logic [NRD*RW-1:0]     rd_idx,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD*TAG_W-1:0]  rd_tag,
    input  logic [RW-1:0]         ren_idx,
    input  logic [TAG_W-1:0]      ren_tag,
    input  logic [NCM-1:0]        cm_valid,
    input  logic [NCM*RW-1:0]     cm_idx,
    input  logic [NCM*XLEN-1:0]   cm_data,
    input  logic [NCM*TAG_W-1:0]  cm_tag,
    output logic [RW:0]           busy_cnt
);

    logic [XLEN-1:0]       data_q   [NREG];
    logic [XLEN-1:0]       data_d   [NREG];
    logic [TAG_W-1:0]      tag_q    [NREG];
    logic [TAG_W-1:0]      tag_d    [NREG];
    logic [RW:0]           busy_q;
    logic [RW:0]           busy_d;
    logic [NCM-1:0]        cm_hit_s [NREG];
    logic [NREG-1:0]       wr_en_s;
    logic [XLEN-1:0]       wr_val_s [NREG];
    logic [NREG-1:0]       tag_clr_s;
    logic [NREG*XLEN-1:0]  data_flat_s;
    logic [NREG*TAG_W-1:0] tag_flat_s;

    // Decode which commit ports address which register (register 0 never written).
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            for (int p = 0; p < NCM; p++) begin
                cm_hit_s[r][p] = cm_valid[p] && (r != EMPTY_REG)
                                 && (int'(cm_idx[p*RW +: RW]) == r);
            end
        end
    end

    // Later ports overwrite earlier ones, so the highest-numbered port wins both data and tag check.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            wr_en_s[r]   = 1'b0;
            wr_val_s[r]  = data_q[r];
            tag_clr_s[r] = 1'b0;
            for (int p = 0; p < NCM; p++) begin
                wr_en_s[r]   = wr_en_s[r] | cm_hit_s[r][p];
                wr_val_s[r]  = cm_hit_s[r][p] ? cm_data[p*XLEN +: XLEN] : wr_val_s[r];
                tag_clr_s[r] = cm_hit_s[r][p] ? (cm_tag[p*TAG_W +: TAG_W] == tag_q[r])
                                              : tag_clr_s[r];
            end
        end
    end

    // Next state: clear beats rename, rename beats a retiring commit; busy is recounted from tag_d.
    always_comb begin
        busy_d = '0;
        for (int r = 0; r < NREG; r++) begin
            if (r == EMPTY_REG) begin
                data_d[r] = '0;
                tag_d[r]  = '0;
            end else begin
                data_d[r] = wr_en_s[r] ? wr_val_s[r] : data_q[r];
                if (clear) begin
                    tag_d[r] = TAG_W'(EMPTY_TAG);
                end else if (int'(ren_idx) == r) begin
                    tag_d[r] = ren_tag;
                end else if (tag_clr_s[r]) begin
                    tag_d[r] = TAG_W'(EMPTY_TAG);
                end else begin
                    tag_d[r] = tag_q[r];
                end
            end
            busy_d = busy_d + ((tag_d[r] != TAG_W'(EMPTY_TAG)) ? (RW+1)'(1) : (RW+1)'(0));
        end
    end

    // State registers; rdy low freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q <= '0;
        end else if (rdy) begin
            for (int r = 0; r < NREG; r++) begin
                data_q[r] <= data_d[r];
                tag_q[r]  <= tag_d[r];
            end
            busy_q <= busy_d;
        end
    end

    // Flatten the arrays for the read-port lookups.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            data_flat_s[r*XLEN +: XLEN]  = data_q[r];
            tag_flat_s[r*TAG_W +: TAG_W] = tag_q[r];
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        rf_read_port #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .TAG_W (TAG_W),
            .NCM   (NCM),
            .RW    (RW)
        ) u_rd (
            .rd_idx    (rd_idx[g*RW +: RW]),
            .data_flat (data_flat_s),
            .tag_flat  (tag_flat_s),
            .cm_valid  (cm_valid),
            .cm_idx    (cm_idx),
            .cm_data   (cm_data),
            .cm_tag    (cm_tag),
            .rd_data   (rd_data[g*XLEN +: XLEN]),
            .rd_tag    (rd_tag[g*TAG_W +: TAG_W])
        );
    end

    assign busy_cnt = busy_q;

endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed vector table, reset corner case, random model run.
module tb_rename_regfile;
    import rf_pkg::*;

    localparam int XLEN = 32, NREG = 32, TAG_W = 4, NRD = 2, NCM = 2, RW = 5;
`ifdef RENAME_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst, rdy, clear;
    logic [NRD*RW-1:0]    rd_idx;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD*TAG_W-1:0] rd_tag;
    logic [RW-1:0]        ren_idx;
    logic [TAG_W-1:0]     ren_tag;
    logic [NCM-1:0]       cm_valid;
    logic [NCM*RW-1:0]    cm_idx;
    logic [NCM*XLEN-1:0]  cm_data;
    logic [NCM*TAG_W-1:0] cm_tag;
    logic [RW:0]          busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rename_regfile #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD), .NCM(NCM)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .rd_idx(rd_idx), .rd_data(rd_data), .rd_tag(rd_tag),
        .ren_idx(ren_idx), .ren_tag(ren_tag),
        .cm_valid(cm_valid), .cm_idx(cm_idx), .cm_data(cm_data), .cm_tag(cm_tag),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rdy;
        logic             clr;
        logic [RW-1:0]    ren_idx;
        logic [TAG_W-1:0] ren_tag;
        logic [NCM-1:0]   cmv;
        logic [RW-1:0]    ci [NCM];
        logic [XLEN-1:0]  cd [NCM];
        logic [TAG_W-1:0] ct [NCM];
        logic [RW-1:0]    ri [NRD];
    } stim_t;

    typedef struct {
        int               id;
        logic [XLEN-1:0]  d [NRD];
        logic [TAG_W-1:0] t [NRD];
        logic [RW:0]      busy;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tbl[$];
    exp_t sbq[$];

    logic [XLEN-1:0]  m_data [NREG];
    logic [TAG_W-1:0] m_tag  [NREG];

    function automatic stim_t idle_stim();
        stim_t s;
        s.rdy = 1'b1; s.clr = 1'b0; s.ren_idx = '0; s.ren_tag = '0; s.cmv = '0;
        for (int p = 0; p < NCM; p++) begin
            s.ci[p] = '0; s.cd[p] = '0; s.ct[p] = '0;
        end
        for (int g = 0; g < NRD; g++) s.ri[g] = '0;
        return s;
    endfunction

    function automatic vec_t mkv(int id, logic r, logic c, int ren_i, int ren_t, logic [1:0] cmv,
                                 int ci0, int cd0, int ct0, int ci1, int cd1, int ct1,
                                 int ri0, int ri1, int ed0, int et0, int ed1, int et1, int busy);
        vec_t v;
        v.s = idle_stim();
        v.s.rdy = r; v.s.clr = c;
        v.s.ren_idx = RW'(ren_i); v.s.ren_tag = TAG_W'(ren_t); v.s.cmv = cmv;
        v.s.ci[0] = RW'(ci0); v.s.cd[0] = XLEN'(cd0); v.s.ct[0] = TAG_W'(ct0);
        v.s.ci[1] = RW'(ci1); v.s.cd[1] = XLEN'(cd1); v.s.ct[1] = TAG_W'(ct1);
        v.s.ri[0] = RW'(ri0); v.s.ri[1] = RW'(ri1);
        v.e.id = id;
        v.e.d[0] = XLEN'(ed0); v.e.t[0] = TAG_W'(et0);
        v.e.d[1] = XLEN'(ed1); v.e.t[1] = TAG_W'(et1);
        v.e.busy = (RW+1)'(busy);
        return v;
    endfunction

    task automatic drive(input stim_t s);
        rdy = s.rdy; clear = s.clr; ren_idx = s.ren_idx; ren_tag = s.ren_tag; cm_valid = s.cmv;
        for (int p = 0; p < NCM; p++) begin
            cm_idx[p*RW +: RW]       = s.ci[p];
            cm_data[p*XLEN +: XLEN]  = s.cd[p];
            cm_tag[p*TAG_W +: TAG_W] = s.ct[p];
        end
        for (int g = 0; g < NRD; g++) rd_idx[g*RW +: RW] = s.ri[g];
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic compare_exp(input exp_t e);
        for (int g = 0; g < NRD; g++) begin
            chk($sformatf("v%0d rd_data%0d", e.id, g), 32'(rd_data[g*XLEN +: XLEN]), 32'(e.d[g]));
            chk($sformatf("v%0d rd_tag%0d", e.id, g), 32'(rd_tag[g*TAG_W +: TAG_W]), 32'(e.t[g]));
        end
        chk($sformatf("v%0d busy_cnt", e.id), 32'(busy_cnt), 32'(e.busy));
    endtask

    // One cycle: drive after the edge, queue the expectation, check on the falling edge.
    task automatic cycle(input stim_t s, input exp_t e);
        exp_t got_e;
        @(posedge clk); #1;
        drive(s);
        sbq.push_back(e);
        @(negedge clk);
        if (sbq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard empty at v%0d", e.id);
        end else begin
            got_e = sbq.pop_front();
            compare_exp(got_e);
        end
    endtask

    function automatic exp_t model_read(input stim_t s, input int id);
        exp_t e;
        int idx;
        logic hit;
        logic [XLEN-1:0] hd;
        e.id = id;
        e.busy = '0;
        for (int r = 0; r < NREG; r++) e.busy = e.busy + ((m_tag[r] != '0) ? (RW+1)'(1) : (RW+1)'(0));
        for (int g = 0; g < NRD; g++) begin
            idx = int'(s.ri[g]);
            hit = 1'b0; hd = '0;
            for (int p = 0; p < NCM; p++) begin
                if (s.cmv[p] && (int'(s.ci[p]) == idx)) begin
                    hit = (s.ct[p] == m_tag[idx]);
                    hd  = s.cd[p];
                end
            end
            if (idx == 0) begin
                e.d[g] = '0; e.t[g] = '0;
            end else if (BYP && hit) begin
                e.d[g] = hd; e.t[g] = '0;
            end else if (m_tag[idx] == '0) begin
                e.d[g] = m_data[idx]; e.t[g] = '0;
            end else begin
                e.d[g] = '0; e.t[g] = m_tag[idx];
            end
        end
        return e;
    endfunction

    task automatic model_step(input stim_t s);
        logic             wv [NREG];
        logic [TAG_W-1:0] wt [NREG];
        if (s.rdy) begin
            for (int r = 0; r < NREG; r++) begin wv[r] = 1'b0; wt[r] = '0; end
            for (int p = 0; p < NCM; p++) begin
                if (s.cmv[p] && s.ci[p] != '0) begin
                    m_data[s.ci[p]] = s.cd[p];
                    wv[s.ci[p]] = 1'b1;
                    wt[s.ci[p]] = s.ct[p];
                end
            end
            for (int r = 0; r < NREG; r++) begin
                if (wv[r] && (wt[r] == m_tag[r])) m_tag[r] = '0;
            end
            if (s.clr) begin
                for (int r = 0; r < NREG; r++) m_tag[r] = '0;
            end else if (s.ren_idx != '0) begin
                m_tag[s.ren_idx] = s.ren_tag;
            end
        end
    endtask

    initial begin
        #200000;
        n_tests++; n_fail++;
        $display("FAIL watchdog timeout");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        stim_t s;
        exp_t  e;

        rst = 1'b1;
        drive(idle_stim());
        repeat (2) @(posedge clk);
        #1;
        chk("busy in reset", 32'(busy_cnt), 32'd0);
        rst = 1'b0;

        //         id rdy clr ren    cmv    ci0 cd0    ct0 ci1 cd1   ct1 ri0 ri1 ed0               et0          ed1           et1          busy
        tbl.push_back(mkv( 1, 1, 0, 0, 0, 2'b00, 0, 0,     0, 0, 0,    0, 5, 0, 0,                0,           0,            0,           0));
        tbl.push_back(mkv( 2, 1, 0, 5, 3, 2'b00, 0, 0,     0, 0, 0,    0, 5, 0, 0,                0,           0,            0,           0));
        tbl.push_back(mkv( 3, 1, 0, 0, 0, 2'b01, 5, 'hAB,  3, 0, 0,    0, 5, 0, BYP ? 'hAB : 0,   BYP ? 0 : 3, 0,            0,           1));
        tbl.push_back(mkv( 4, 1, 0, 5, 3, 2'b00, 0, 0,     0, 0, 0,    0, 5, 0, 'hAB,             0,           0,            0,           0));
        tbl.push_back(mkv( 5, 1, 0, 5, 7, 2'b00, 0, 0,     0, 0, 0,    0, 5, 0, 0,                3,           0,            0,           1));
        tbl.push_back(mkv( 6, 1, 0, 0, 0, 2'b10, 0, 0,     0, 5, 'h11, 3, 5, 0, 0,                7,           0,            0,           1));
        tbl.push_back(mkv( 7, 1, 1, 0, 0, 2'b00, 0, 0,     0, 0, 0,    0, 5, 0, 0,                7,           0,            0,           1));
        tbl.push_back(mkv( 8, 1, 0, 0, 0, 2'b11, 9, 1,     0, 9, 2,    0, 5, 9, 'h11,             0,           BYP ? 2 : 0,  0,           0));
        tbl.push_back(mkv( 9, 1, 0, 1, 1, 2'b00, 0, 0,     0, 0, 0,    0, 9, 9, 2,                0,           2,            0,           0));
        tbl.push_back(mkv(10, 1, 0, 2, 2, 2'b00, 0, 0,     0, 0, 0,    0, 1, 0, 0,                1,           0,            0,           1));
        tbl.push_back(mkv(11, 1, 0, 3, 3, 2'b00, 0, 0,     0, 0, 0,    0, 2, 1, 0,                2,           0,            1,           2));
        tbl.push_back(mkv(12, 1, 1, 4, 4, 2'b01, 2, 'h55,  9, 0, 0,    0, 3, 2, 0,                3,           0,            2,           3));
        tbl.push_back(mkv(13, 1, 0, 0, 5, 2'b00, 0, 0,     0, 0, 0,    0, 2, 4, 'h55,             0,           0,            0,           0));
        tbl.push_back(mkv(14, 1, 0, 4, 2, 2'b00, 0, 0,     0, 0, 0,    0, 0, 1, 0,                0,           0,            0,           0));
        tbl.push_back(mkv(15, 1, 0, 0, 0, 2'b01, 4, 'h99,  2, 0, 0,    0, 4, 4, BYP ? 'h99 : 0,   BYP ? 0 : 2, BYP ? 'h99 : 0, BYP ? 0 : 2, 1));
        tbl.push_back(mkv(16, 1, 0, 6, 5, 2'b01, 6, 'h77,  0, 0, 0,    0, 4, 0, 'h99,             0,           0,            0,           0));
        tbl.push_back(mkv(17, 0, 1, 7, 1, 2'b00, 0, 0,     0, 0, 0,    0, 6, 7, 0,                5,           0,            0,           1));
        tbl.push_back(mkv(18, 1, 0, 0, 0, 2'b11, 6, 'h88,  5, 6, 'h44, 4, 6, 7, 0,                5,           0,            0,           1));
        tbl.push_back(mkv(19, 1, 1, 0, 0, 2'b00, 0, 0,     0, 0, 0,    0, 6, 0, 0,                5,           0,            0,           1));
        tbl.push_back(mkv(20, 1, 0, 0, 0, 2'b00, 0, 0,     0, 0, 0,    0, 6, 0, 'h44,             0,           0,            0,           0));

        for (int i = 0; i < tbl.size(); i++) cycle(tbl[i].s, tbl[i].e);

        // Asynchronous reset between edges overrides a pending clear/commit/rename.
        @(posedge clk); #1;
        s = idle_stim(); s.ren_idx = RW'(8); s.ren_tag = TAG_W'(6);
        drive(s);
        @(posedge clk); #1;
        chk("pre-rst busy", 32'(busy_cnt), 32'd1);
        s = idle_stim(); s.clr = 1'b1; s.ren_idx = RW'(9); s.ren_tag = TAG_W'(2);
        s.cmv = 2'b01; s.ci[0] = RW'(5); s.cd[0] = 32'h66; s.ct[0] = 4'd0;
        s.ri[0] = RW'(2); s.ri[1] = RW'(8);
        drive(s);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", 32'(busy_cnt), 32'd0);
        chk("async rst x2 data", 32'(rd_data[0 +: XLEN]), 32'd0);
        chk("async rst x8 tag", 32'(rd_tag[TAG_W +: TAG_W]), 32'd0);
        @(posedge clk); #1;
        chk("rst held busy", 32'(busy_cnt), 32'd0);
        rst = 1'b0;
        s.clr = 1'b0;
        drive(s);
        @(posedge clk); #1;
        s = idle_stim(); s.ri[0] = RW'(5); s.ri[1] = RW'(9);
        drive(s);
        #1;
        chk("post-rst x5 data", 32'(rd_data[0 +: XLEN]), 32'h66);
        chk("post-rst x9 tag", 32'(rd_tag[TAG_W +: TAG_W]), 32'd2);
        chk("post-rst busy", 32'(busy_cnt), 32'd1);

        // Random run against a behavioural model from a fresh reset.
        rst = 1'b1;
        #3 rst = 1'b0;
        for (int r = 0; r < NREG; r++) begin m_data[r] = '0; m_tag[r] = '0; end
        for (int i = 0; i < 300; i++) begin
            s = idle_stim();
            s.rdy = ($urandom_range(0, 9) != 0);
            s.clr = ($urandom_range(0, 19) == 0);
            s.ren_idx = RW'($urandom_range(0, 7));
            s.ren_tag = TAG_W'($urandom_range(1, 7));
            s.cmv = s.rdy ? NCM'($urandom_range(0, 3)) : '0;
            for (int p = 0; p < NCM; p++) begin
                s.ci[p] = RW'($urandom_range(0, 7));
                s.cd[p] = XLEN'($urandom);
                s.ct[p] = TAG_W'($urandom_range(0, 7));
            end
            for (int g = 0; g < NRD; g++) s.ri[g] = RW'($urandom_range(0, 7));
            e = model_read(s, 1000 + i);
            cycle(s, e);
            model_step(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
